// File: rtl/music_player.sv
// Song sequencer and square-wave tone generator. It walks the song ROM address,
// holds each note for its duration, and puts a silent gap after every note.
module music_player #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TICK_HZ    = 8,
  parameter int GAP_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [19:0] note,
  input  logic [4:0]  duration,
  input  logic        done,
  output logic [9:0]  number,
  output logic        speaker,
  output logic        playing,
  output logic        finished
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // GAP_CYCLES of 0 or 1 both give a single gap cycle
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FINISH} state_t;

  state_t      state_q, state_d;
  logic [9:0]  number_q, number_d;
  logic        speaker_q, speaker_d;
  logic        playing_q, playing_d;
  logic        finished_q, finished_d;
  logic [19:0] note_q, note_d;
  logic [4:0]  dur_q, dur_d;
  logic [4:0]  unit_q, unit_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [18:0] tone_q, tone_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [18:0] half_p;

  assign half_p = note_q[19:1];

  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    speaker_d = 1'b0;
    note_d    = note_q;
    dur_d     = dur_q;
    unit_d    = unit_q;
    tick_d    = tick_q;
    tone_d    = tone_q;
    gap_d     = gap_q;
    case (state_q)
      IDLE: begin
        number_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (done) begin
          state_d  = FINISH;
          number_d = '0;
        end else begin
          note_d  = note;
          dur_d   = (duration == 5'd0) ? 5'd1 : duration;
          unit_d  = '0;
          tick_d  = '0;
          tone_d  = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (note_q >= 20'd2) begin
          speaker_d = speaker_q;
          if (tone_q == half_p - 19'd1) begin
            tone_d    = '0;
            speaker_d = ~speaker_q;
          end else begin
            tone_d = tone_q + 19'd1;
          end
        end
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          unit_d = unit_q + 5'd1;
          if (unit_d == dur_q) begin
            state_d   = GAP;
            gap_d     = '0;
            number_d  = number_q + 10'd1;
            speaker_d = 1'b0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = LOAD;
        else gap_d = gap_q + GW'(1);
      end
      FINISH: begin
        number_d = '0;
        state_d  = loop ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // stop overrides everything, including a start in the same cycle
    if (stop) begin
      state_d   = IDLE;
      number_d  = '0;
      speaker_d = 1'b0;
      unit_d    = '0;
      tick_d    = '0;
      tone_d    = '0;
      gap_d     = '0;
    end
    playing_d  = (state_d == LOAD) || (state_d == PLAY) || (state_d == GAP);
    finished_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      number_q   <= '0;
      speaker_q  <= 1'b0;
      playing_q  <= 1'b0;
      finished_q <= 1'b0;
      note_q     <= '0;
      dur_q      <= '0;
      unit_q     <= '0;
      tick_q     <= '0;
      tone_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      speaker_q  <= speaker_d;
      playing_q  <= playing_d;
      finished_q <= finished_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      unit_q     <= unit_d;
      tick_q     <= tick_d;
      tone_q     <= tone_d;
      gap_q      <= gap_d;
    end
  end

  assign number   = number_q;
  assign speaker  = speaker_q;
  assign playing  = playing_q;
  assign finished = finished_q;
endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a small ROM model (TICK_DIV=10, GAP=2).
module tb_music_player;
  logic        clk = 1'b0;
  logic        reset, start, stop, loop;
  logic [19:0] note;
  logic [4:0]  duration;
  logic        done;
  logic [9:0]  number;
  logic        speaker, playing, finished;

  logic [19:0] rn [0:15];
  logic [4:0]  rd [0:15];
  logic        rdn[0:15];

  int total = 0;
  int bad   = 0;

  music_player #(.CLK_FREQ(1000), .TICK_HZ(100), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .note(note), .duration(duration), .done(done),
    .number(number), .speaker(speaker), .playing(playing), .finished(finished)
  );

  always #5 clk = ~clk;

  assign note     = rn[number[3:0]];
  assign duration = rd[number[3:0]];
  assign done     = rdn[number[3:0]];

  // Expected {playing, speaker, finished, number} at cycle k after the start
  // edge (k=1 is LOAD) for a one-note song; half=0 means a rest.
  function automatic logic [12:0] exp1(int k, int half, int plen);
    int c;
    if (k == 1) return {3'b100, 10'd0};
    if (k >= 2 && k <= plen + 1) begin
      c = k - 2;
      if (half == 0) return {3'b100, 10'd0};
      return {1'b1, 1'(((c / half) % 2)), 1'b0, 10'd0};
    end
    if (k == plen + 2 || k == plen + 3 || k == plen + 4) return {3'b100, 10'd1};
    if (k == plen + 5) return {3'b001, 10'd0};
    return 13'd0;
  endfunction

  task automatic set_song(input logic [19:0] n0, input logic [4:0] d0);
    for (int i = 0; i < 16; i++) begin
      rn[i] = '0; rd[i] = '0; rdn[i] = 1'b1;
    end
    rn[0] = n0; rd[0] = d0; rdn[0] = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start then check a single pass cycle by cycle
  task automatic run_pass(input string nm, input int half, input int plen, input int ncyc);
    logic [12:0] obs, exp;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk); start = 1'b0;
      obs = {playing, speaker, finished, number};
      exp = exp1(k, half, plen);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s k=%0d got=%h exp=%h", nm, k, obs, exp);
      end
    end
  endtask

  task automatic test_reset;
    logic [12:0] obs;
    do_reset();
    obs = {playing, speaker, finished, number};
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset got=%h exp=0", obs);
    end
  endtask

  task automatic test_basic;
    do_reset(); set_song(20'd20, 5'd2);
    run_pass("basic", 10, 20, 28);
  endtask

  task automatic test_rest;
    do_reset(); set_song(20'd1, 5'd1);
    run_pass("rest", 0, 10, 18);
  endtask

  task automatic test_zero_dur;
    do_reset(); set_song(20'd8, 5'd0);
    run_pass("zero_dur", 4, 10, 18);
  endtask

  task automatic test_loop;
    logic [12:0] obs, exp;
    int fins;
    do_reset(); set_song(20'd20, 5'd2);
    loop = 1'b1; fins = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk); start = 1'b0;
      obs = {playing, speaker, finished, number};
      exp = exp1(((k - 1) % 25) + 1, 10, 20);
      if (finished === 1'b1) fins++;
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL loop k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
    total++;
    if (fins !== 2) begin
      bad++; $display("FAIL loop_fin_count got=%0d exp=2", fins);
    end
    stop = 1'b1; @(negedge clk); stop = 1'b0; loop = 1'b0;
    obs = {playing, speaker, finished, number};
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL loop_stop got=%h exp=0", obs);
    end
  endtask

  task automatic test_stop;
    logic [12:0] obs, exp;
    do_reset(); set_song(20'd4, 5'd2);
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); start = 1'b0;
      obs = {playing, speaker, finished, number};
      exp = exp1(k, 2, 20);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL stop_pre k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); stop = 1'b0;
      obs = {playing, speaker, finished, number};
      total++;
      if (obs !== 13'd0) begin
        bad++; $display("FAIL stop_idle k=%0d got=%h exp=0", k, obs);
      end
    end
    run_pass("stop_restart", 2, 20, 28);
  endtask

  task automatic test_start_reset;
    logic [12:0] obs, exp;
    do_reset(); set_song(20'd20, 5'd2);
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = (k == 5) ? 1'b1 : 1'b0;
      obs = {playing, speaker, finished, number};
      exp = exp1(k, 10, 20);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL start_in_play k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
    start = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    obs = {playing, speaker, finished, number};
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_in_gap got=%h exp=0", obs);
    end
    @(negedge clk);
    obs = {playing, speaker, finished, number};
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL idle_after_reset got=%h exp=0", obs);
    end
  endtask

  initial begin
    set_song(20'd0, 5'd0);
    test_reset();
    test_basic();
    test_rest();
    test_zero_dur();
    test_loop();
    test_stop();
    test_start_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Sequencer and tone generator that drives the song ROM address (number) and consumes its note / duration / done outputs.
- Steps through the score, holds each note for its duration, and emits a square wave on a single speaker pin.
- Inserts a short silent gap between notes so repeated notes articulate.
- Sits between the song ROM and the board audio pin; start, stop and loop come from debounced board controls.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
TICK_HZ, 8, duration unit rate in Hz; 1 duration count = 1/TICK_HZ s (QUARTER=2 gives 0.25 s)
GAP_CYCLES, 500000, silent clocks inserted after every note (10 ms at 50 MHz)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins playback from number 0
stop  in  1  level; aborts playback while high
loop  in  1  when 1, restart at number 0 after done
note  in  20  from ROM: tone period in clk cycles (values 0 or 1 = rest)
duration  in  5  from ROM: note length in duration units
done  in  1  from ROM: end-of-song marker for the current number
number  out  10  ROM address, registered
speaker  out  1  square-wave audio output, registered
playing  out  1  high in LOAD, PLAY and GAP
finished  out  1  one-cycle pulse when done is reached

Behaviour:
- TICK_DIV = CLK_FREQ/TICK_HZ (integer). HALF_P = note_r >> 1.
- Reset: state=IDLE, number=0, speaker=0, playing=0, finished=0, all counters 0.
- Priority: reset > stop > start > normal sequencing.
- stop=1 in any state: next cycle state=IDLE, number=0, speaker=0. start is ignored while stop=1.
- IDLE: number held at 0. A start pulse moves to LOAD on the next edge. start pulses outside IDLE are ignored (no restart).
- LOAD (1 cycle): ROM is combinational on registered number, so its outputs are valid in this cycle.
  - If done=1: go to FINISH.
  - Otherwise latch note_r=note and dur_r=max(duration,1), clear the tick, unit and tone counters, go to PLAY.
- PLAY:
  - Tick prescaler counts 0..TICK_DIV-1. On wrap, the unit counter increments.
  - When the unit counter reaches dur_r on a wrap, go to GAP. PLAY lasts exactly dur_r*TICK_DIV cycles.
- Tone generation (PLAY only):
  - If note_r<2: speaker=0 (rest).
  - Otherwise the tone counter counts 0..HALF_P-1; speaker toggles on wrap, giving period 2*HALF_P clocks.
  - The first toggle (0->1) occurs HALF_P cycles after entering PLAY.
- GAP:
  - speaker=0. number increments on GAP entry; 1023 wraps to 0.
  - Counts GAP_CYCLES cycles, then goes to LOAD.
  - GAP_CYCLES=0 means GAP lasts 1 cycle.
- FINISH (1 cycle): finished=1, speaker=0, number cleared to 0.
  - loop=1: next state LOAD.
  - loop=0: next state IDLE.
- speaker is 0 in IDLE, LOAD, GAP and FINISH. Returning to PLAY always starts the tone from speaker=0.
- playing is a registered decode of next state, so it is aligned with state.
- Reset or stop mid-note: counters cleared, no finished pulse, and the next start replays from number 0.

Test Plan:
All scenarios use CLK_FREQ=1000, TICK_HZ=100 (TICK_DIV=10), GAP_CYCLES=2, and a bench ROM model.
1. ROM[0]: note=20, duration=2; ROM[1]: done=1. Pulse start -> LOAD for 1 cycle; PLAY for 20 cycles with speaker toggling every 10 clocks (0→1 at PLAY cycle 10); GAP for 2 cycles; number becomes 1; LOAD; FINISH; finished high for exactly 1 cycle; back in IDLE with number=0 and playing=0.
2. ROM[0]: note=1, duration=1, followed by done. speaker stays 0 for all 10 PLAY cycles; playing=1 throughout.
3. ROM[0]: duration=0. Treated as 1 unit, so PLAY lasts 10 cycles.
4. Same ROM as scenario 1 with loop=1. After FINISH, number=0, then LOAD and PLAY repeat; finished pulses once per pass.
5. Assert stop for 1 cycle at PLAY cycle 7. Next cycle: IDLE, speaker=0, number=0, no finished pulse. A start pulse 3 cycles later restarts from number 0.
6. Pulse start during PLAY -> no effect on number or counters. Assert reset during GAP -> all outputs return to reset values on the next edge.
